// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop rx synchronizer, mid-bit sampling, LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 parity_err
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_nxt;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  assign cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (os_tick) begin
          if (cnt_q == MID) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_nxt;
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          cnt_d = cnt_nxt;
          if (cnt_q == LAST) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (os_tick) begin
          cnt_d = cnt_nxt;
          if (cnt_q == LAST) begin
            par_bad_d = ^{shift_q, rx_s_q};
            state_d   = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (os_tick) begin
          cnt_d = cnt_nxt;
          if (cnt_q == LAST) begin
            data_d  = shift_q;
            valid_d = rx_s_q;
            ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 4 clk per os_tick, 16 os_tick per bit.
// Parity-specific vectors run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       os_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic       parity_err;
  logic [1:0] div = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_pv = 0;
  int n_both = 0;
  int run_len = 0;
  int busy_len = 0;
  logic       busy_prev = 1'b0;
  logic       busy_seen = 1'b0;
  logic [7:0] last_data = '0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .os_tick(os_tick),
    .rx(rx),
    .data_out(data_out),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div     <= div + 2'd1;
    os_tick <= (div == 2'd2);
  end

  always @(negedge clk) begin
    if (valid) begin
      n_valid   = n_valid + 1;
      last_data = data_out;
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (parity_err) n_perr = n_perr + 1;
    if (parity_err && valid) n_pv = n_pv + 1;
    if (valid && frame_err) n_both = n_both + 1;
    if (busy) busy_seen = 1'b1;
    if (busy && !busy_prev) run_len = 1;
    else if (busy) run_len = run_len + 1;
    if (!busy && busy_prev) busy_len = run_len;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    send_bit(par, BIT_CLKS);
`else
    if (par !== par) send_bit(1'b1, 1);
`endif
    send_bit(stop, BIT_CLKS);
    rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data_out}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'h55, 1'b1, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    chk("f55_nvalid", n_valid, 1);
    chk("f55_data", {24'd0, last_data}, 32'h55);
    chk("f55_ferr", n_ferr, 0);
    chk("f55_busy_len", {31'd0, busy_len >= 600 && busy_len <= 616}, 1);

    send_frame(8'h00, 1'b1, 1'b0);
    chk("b2b0_data", {24'd0, last_data}, 32'h00);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("b2b_nvalid", n_valid, 3);
    chk("b2b1_data", {24'd0, data_out}, 32'hFF);

    busy_seen = 1'b0;
    send_bit(1'b0, 16);
    send_bit(1'b1, 2 * BIT_CLKS);
    chk("glitch_busy_seen", {31'd0, busy_seen}, 1);
    chk("glitch_nvalid", n_valid, 3);
    chk("glitch_nferr", n_ferr, 0);
    chk("glitch_busy", {31'd0, busy}, 0);

    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_nvalid", n_valid, 3);
    chk("ferr_data", {24'd0, data_out}, 32'hA3);
    chk("ferr_busy", {31'd0, busy}, 0);

    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(i < 2 ? 1'b0 : 1'b1, BIT_CLKS);
    send_bit(1'b1, BIT_CLKS / 2);
    chk("abort_busy_pre", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("abort_data", {24'd0, data_out}, 32'h00);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_valid", {31'd0, valid}, 0);
    chk("abort_ferr", {31'd0, frame_err}, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_pulse", n_valid + n_ferr, 4);

    send_frame(8'hC5, 1'b1, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    chk("c5_nvalid", n_valid, 4);
    chk("c5_data", {24'd0, data_out}, 32'hC5);
    chk("c5_nferr", n_ferr, 1);

`ifdef UART_RX_PARITY_EN
    chk("par_none_yet", n_perr, 0);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    chk("par_nvalid", n_valid, 5);
    chk("par_data", {24'd0, data_out}, 32'h07);
    chk("par_nperr", n_perr, 1);
    chk("par_with_valid", n_pv, 1);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("par_ok_nvalid", n_valid, 6);
    chk("par_ok_nperr", n_perr, 1);
`else
    chk("noparity_perr", n_perr, 0);
`endif
    chk("never_both", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, os_tick pulses per bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port os_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port data_out  output  DATA_BITS  last received byte.
REQ-008 SHALL have port valid  output  1  one-clk pulse: good frame on data_out.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port parity_err  output  1  one-clk pulse: parity mismatch (UART_RX_PARITY_EN builds only).

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, STOP (PARITY between DATA and STOP when UART_RX_PARITY_EN).
REQ-014 IDLE: rx_s==0 on any clk -> START, tick counter cleared to 0; busy asserts the same edge.
REQ-015 Tick counter SHALL increment only on os_tick and wrap from OVERSAMPLE-1 to 0.
REQ-016 START: at counter OVERSAMPLE/2-1 with os_tick, rx_s==0 -> DATA, counter cleared; rx_s==1 -> IDLE (glitch reject, no outputs).
REQ-017 DATA: sample rx_s at each counter==OVERSAMPLE-1 with os_tick into shift register, LSB first; after DATA_BITS samples -> STOP (or PARITY).
REQ-018 PARITY: sample at OVERSAMPLE-1; even parity over data plus parity bit; mismatch latched for STOP.
REQ-019 STOP: sample at OVERSAMPLE-1; 1 -> valid pulse; 0 -> frame_err pulse; data_out updated in both cases; -> IDLE same edge.
REQ-020 valid and frame_err SHALL never assert together; parity_err pulses with valid or frame_err of the same frame.
REQ-021 data_out SHALL hold its value until the next frame completes.
REQ-022 busy SHALL deassert on the edge leaving STOP; a start edge on the next clk SHALL be accepted (back-to-back frames).
REQ-023 os_tick coincident with the IDLE->START edge SHALL not advance the counter.
REQ-024 rx changes outside IDLE SHALL affect only sample points; no resync mid-frame.

Reset
REQ-025 rst high SHALL immediately force IDLE, counter 0, shift register 0, synchronizer 1s, data_out 0, valid 0, frame_err 0, parity_err 0, busy 0.
REQ-026 rst mid-frame SHALL abort the frame with no valid or error pulse; receiver reacquires on the first falling edge after release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state present, frame = start + DATA_BITS + even parity + stop, parity_err driven per REQ-018.
REQ-028 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame = start + DATA_BITS + stop, parity_err tied 0.

Verification
REQ-029 rx frame 0x55 at 16 os_tick/bit -> one valid pulse, data_out=0x55, frame_err=0, busy high for ~9.5 bit periods.
REQ-030 Back-to-back frames 0x00 then 0xFF, no idle gap -> two valid pulses, data_out 0x00 then 0xFF.
REQ-031 rx low for 4 os_ticks then high -> no valid, no frame_err, busy returns to 0, state IDLE.
REQ-032 Frame 0xA3 with stop bit driven 0 -> frame_err pulse, valid=0, data_out=0xA3.
REQ-033 rst asserted during data bit 4 of frame 0x3C -> all outputs 0 at once; next frame 0xC5 -> valid, data_out=0xC5.
REQ-034 UART_RX_PARITY_EN build, frame 0x07 with parity bit 0 -> valid and parity_err pulse together, data_out=0x07.
